// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: round-robin arbiter that accepts add/mul requests from
// NREQ requesters, issues them one at a time to a shared ALU, enforces a
// minimum idle gap after every start, and reports completion to the owner.
module alu_req_arbiter #(
  parameter int NREQ    = 4,
  parameter int OPW     = 8,
  parameter int AW      = 20,
  parameter int MIN_GAP = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ*OPW-1:0] req_opcode,
  input  logic [NREQ*AW-1:0]  req_addr,
  output logic [NREQ-1:0]     gnt,
  output logic [NREQ-1:0]     rej,
  output logic [NREQ-1:0]     done,
  output logic                busy,
  output logic                alu_start,
  output logic [OPW-1:0]      alu_opcode,
  output logic [AW-1:0]       alu_addr,
  input  logic                alu_ready
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (MIN_GAP > 1) ? $clog2(MIN_GAP + 1) : 1;
  localparam logic [OPW-1:0] OP_ADD = OPW'(8'h05);
  localparam logic [OPW-1:0] OP_MUL = OPW'(8'h06);

  typedef enum logic [2:0] {IDLE, ISSUE, GAP, WAIT, DONE} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   gapCnt_q, gapCnt_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic [OPW-1:0]  opcode_q, opcode_d;
  logic [AW-1:0]   addr_q, addr_d;

  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] rej_q, rej_d;
  logic [NREQ-1:0] done_q, done_d;
  logic            busy_q, busy_d;
  logic            start_q, start_d;

  logic            found;
  logic [PW-1:0]   winner;
  logic [OPW-1:0]  winOpcode;
  logic [AW-1:0]   winAddr;
  logic            winLegal;
  logic            arbValid;

  function automatic logic [PW-1:0] ptrInc(input logic [PW-1:0] x);
    return PW'((int'(x) + 1) % NREQ);
  endfunction

  // Round-robin search upward from ptr; only meaningful while idle with a ready ALU
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req[(int'(ptr_q) + k) % NREQ]) begin
        found  = 1'b1;
        winner = PW'((int'(ptr_q) + k) % NREQ);
      end
    end
    winOpcode = req_opcode[winner*OPW +: OPW];
    winAddr   = req_addr[winner*AW +: AW];
    winLegal  = (winOpcode == OP_ADD) || (winOpcode == OP_MUL);
    arbValid  = (state_q == IDLE) && alu_ready && found;
  end

  // Next-state logic: arbitration in IDLE, then a fixed ISSUE/GAP/WAIT/DONE walk
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gapCnt_d = gapCnt_q;
    owner_d  = owner_q;
    opcode_d = opcode_q;
    addr_d   = addr_q;
    case (state_q)
      IDLE: begin
        if (arbValid) begin
          if (winLegal) begin
            state_d  = ISSUE;
            owner_d  = winner;
            opcode_d = winOpcode;
            addr_d   = winAddr;
          end else begin
            ptr_d = ptrInc(winner);
          end
        end
      end
      ISSUE: begin
        ptr_d    = ptrInc(owner_q);
        gapCnt_d = '0;
        state_d  = GAP;
      end
      GAP: begin
        if (gapCnt_q == CW'(MIN_GAP - 1)) begin
          state_d = WAIT;
        end else begin
          gapCnt_d = gapCnt_q + CW'(1);
        end
      end
      WAIT: begin
        if (alu_ready) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output values for the coming cycle, derived from the state being entered
  always_comb begin
    gnt_d   = '0;
    rej_d   = '0;
    done_d  = '0;
    start_d = 1'b0;
    busy_d  = (state_d != IDLE);
    if (state_d == ISSUE) begin
      start_d = 1'b1;
      gnt_d   = NREQ'(1) << owner_d;
    end
    if (state_d == DONE) begin
      done_d = NREQ'(1) << owner_q;
    end
    if (arbValid && !winLegal) begin
      rej_d = NREQ'(1) << winner;
    end
  end

  // State, bookkeeping and output registers; reset aborts any operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      gapCnt_q <= '0;
      owner_q  <= '0;
      opcode_q <= '0;
      addr_q   <= '0;
      gnt_q    <= '0;
      rej_q    <= '0;
      done_q   <= '0;
      busy_q   <= 1'b0;
      start_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gapCnt_q <= gapCnt_d;
      owner_q  <= owner_d;
      opcode_q <= opcode_d;
      addr_q   <= addr_d;
      gnt_q    <= gnt_d;
      rej_q    <= rej_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      start_q  <= start_d;
    end
  end

  assign gnt        = gnt_q;
  assign rej        = rej_q;
  assign done       = done_q;
  assign busy       = busy_q;
  assign alu_start  = start_q;
  assign alu_opcode = opcode_q;
  assign alu_addr   = addr_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed self-checking bench for alu_req_arbiter (NREQ=4, OPW=8, AW=20, MIN_GAP=2).
module tb_alu_req_arbiter;

  localparam int NREQ = 4;
  localparam int OPW  = 8;
  localparam int AW   = 20;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NREQ-1:0]     req = '0;
  logic [NREQ*OPW-1:0] req_opcode = '0;
  logic [NREQ*AW-1:0]  req_addr = '0;
  logic [NREQ-1:0]     gnt, rej, done;
  logic                busy, alu_start;
  logic [OPW-1:0]      alu_opcode;
  logic [AW-1:0]       alu_addr;
  logic                alu_ready = 1'b0;

  int nAsserts = 0;
  int nFail = 0;

  alu_req_arbiter #(.NREQ(NREQ), .OPW(OPW), .AW(AW), .MIN_GAP(2)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_opcode(req_opcode),
    .req_addr(req_addr), .gnt(gnt), .rej(rej), .done(done), .busy(busy),
    .alu_start(alu_start), .alu_opcode(alu_opcode), .alu_addr(alu_addr),
    .alu_ready(alu_ready)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    nAsserts++;
    assert (observed === expected) else begin
      nFail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] reqV, input logic readyV);
    req       = reqV;
    alu_ready = readyV;
  endtask

  task automatic setReq(input int i, input logic [OPW-1:0] op, input logic [AW-1:0] addr);
    req_opcode[i*OPW +: OPW] = op;
    req_addr[i*AW +: AW]     = addr;
  endtask

  task automatic stepCycle();
    @(negedge clk);
  endtask

  // Directed sequence: each step waits for a falling edge, checks, then drives
  initial begin
    int lastStart;
    int nStarts;
    logic [NREQ-1:0] expOrder [5];
    expOrder = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    // Reset state
    stepCycle();
    stepCycle();
    checkOutput("rst_gnt", gnt, 0);
    checkOutput("rst_rej", rej, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_start", alu_start, 0);
    checkOutput("rst_opcode", alu_opcode, 0);
    checkOutput("rst_addr", alu_addr, 0);
    rst_n = 1'b1;

    // Single add from requester 0
    setReq(0, 8'h05, 20'h00010);
    applyStimulus(4'b0001, 1'b1);
    stepCycle();
    checkOutput("add_start", alu_start, 1);
    checkOutput("add_gnt", gnt, 4'b0001);
    checkOutput("add_opcode", alu_opcode, 8'h05);
    checkOutput("add_addr", alu_addr, 20'h00010);
    checkOutput("add_busy", busy, 1);
    applyStimulus(4'b0000, 1'b1);
    stepCycle();
    checkOutput("add_start_pulse", alu_start, 0);
    checkOutput("add_gnt_pulse", gnt, 0);
    checkOutput("add_addr_gap", alu_addr, 20'h00010);
    stepCycle();
    stepCycle();
    checkOutput("add_done_wait", done, 0);
    stepCycle();
    checkOutput("add_done", done, 4'b0001);
    checkOutput("add_addr_done", alu_addr, 20'h00010);
    stepCycle();
    checkOutput("add_done_pulse", done, 0);
    checkOutput("add_idle_busy", busy, 0);
    checkOutput("add_addr_hold", alu_addr, 20'h00010);

    // Reset again so the pointer restarts at 0
    rst_n = 1'b0;
    #1;
    checkOutput("rst2_addr", alu_addr, 0);
    stepCycle();
    rst_n = 1'b1;

    // Round-robin with all four requesting mul
    for (int i = 0; i < NREQ; i++) setReq(i, 8'h06, AW'(20'h00100 + i));
    applyStimulus(4'b1111, 1'b1);
    lastStart = 0;
    nStarts = 0;
    for (int cyc = 1; cyc <= 25; cyc++) begin
      stepCycle();
      checkOutput("rr_gnt_with_start", (gnt != 0), alu_start);
      if (alu_start) begin
        if (nStarts < 5) checkOutput($sformatf("rr_gnt%0d", nStarts), gnt, expOrder[nStarts]);
        if (nStarts > 0) checkOutput($sformatf("rr_period%0d", nStarts), cyc - lastStart, 6);
        lastStart = cyc;
        nStarts++;
      end
    end
    checkOutput("rr_nstarts", nStarts, 5);
    applyStimulus(4'b0000, 1'b1);
    repeat (6) stepCycle();
    checkOutput("rr_idle", busy, 0);

    // Illegal opcode from requester 1 (pointer is 1 after owner 0)
    setReq(1, 8'h07, 20'h00aaa);
    applyStimulus(4'b0010, 1'b1);
    stepCycle();
    checkOutput("ill_rej", rej, 4'b0010);
    checkOutput("ill_start", alu_start, 0);
    checkOutput("ill_gnt", gnt, 0);
    checkOutput("ill_busy", busy, 0);
    setReq(1, 8'h05, 20'h00011);
    setReq(2, 8'h06, 20'h00022);
    applyStimulus(4'b0110, 1'b1);
    stepCycle();
    checkOutput("ill_next_gnt", gnt, 4'b0100);
    checkOutput("ill_next_start", alu_start, 1);
    checkOutput("ill_next_opcode", alu_opcode, 8'h06);
    checkOutput("ill_next_addr", alu_addr, 20'h00022);
    checkOutput("ill_rej_pulse", rej, 0);

    // Slow ALU: ready low throughout GAP and ten WAIT cycles
    applyStimulus(4'b0000, 1'b0);
    for (int c = 0; c < 12; c++) begin
      stepCycle();
      checkOutput($sformatf("slow_busy%0d", c), busy, 1);
      checkOutput($sformatf("slow_done%0d", c), done, 0);
    end
    applyStimulus(4'b0000, 1'b1);
    stepCycle();
    checkOutput("slow_done", done, 4'b0100);
    stepCycle();
    checkOutput("slow_done_pulse", done, 0);
    checkOutput("slow_idle", busy, 0);

    // ALU not ready in IDLE holds off the request (pointer is now 3)
    setReq(0, 8'h05, 20'h00033);
    applyStimulus(4'b0001, 1'b0);
    for (int c = 0; c < 5; c++) begin
      stepCycle();
      checkOutput($sformatf("nrdy_gnt%0d", c), gnt, 0);
      checkOutput($sformatf("nrdy_start%0d", c), alu_start, 0);
    end
    applyStimulus(4'b0001, 1'b1);
    stepCycle();
    checkOutput("nrdy_gnt", gnt, 4'b0001);
    checkOutput("nrdy_start", alu_start, 1);

    // Reset while in WAIT, with requester 3 pending
    applyStimulus(4'b0000, 1'b0);
    repeat (3) stepCycle();
    checkOutput("wrst_busy_pre", busy, 1);
    setReq(3, 8'h06, 20'h00044);
    applyStimulus(4'b1000, 1'b0);
    rst_n = 1'b0;
    #1;
    checkOutput("wrst_busy", busy, 0);
    checkOutput("wrst_opcode", alu_opcode, 0);
    checkOutput("wrst_addr", alu_addr, 0);
    stepCycle();
    checkOutput("wrst_done", done, 0);
    rst_n = 1'b1;
    alu_ready = 1'b1;
    #1;
    checkOutput("wrst_no_start", alu_start, 0);
    stepCycle();
    checkOutput("wrst_gnt", gnt, 4'b1000);
    checkOutput("wrst_start", alu_start, 1);
    checkOutput("wrst_addr_new", alu_addr, 20'h00044);
    applyStimulus(4'b0000, 1'b1);
    repeat (3) stepCycle();
    checkOutput("wrst_done_wait", done, 0);
    stepCycle();
    checkOutput("wrst_done_owner", done, 4'b1000);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
